// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory path: access sizes, arbiter FSM states
// and the alignment rule used to flag bad accesses.
package dm_arbiter_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_RMW_WR = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_WORD: return (off != 2'b00);
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and data-memory signals of the arbiter, bundled with modports for
// the arbiter (slave) side and the requester/memory (master) side.
interface dm_arbiter_if #(
  parameter int AW = 9
);
  logic [1:0]    req;
  logic [1:0]    we;
  logic [1:0]    size0;
  logic [1:0]    size1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [31:0]   rdata;
  logic          err;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req, we, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, done, rdata, err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, done, rdata, err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_arbiter_lane.sv
// Little-endian lane logic: extracts a zero-extended load value from a memory
// word and merges a right-aligned store value into it.
module dm_lane
  import dm_arbiter_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [4:0]  w_sh;
  logic [31:0] w_bmask;

  assign w_sh    = {i_off, 3'b000};
  assign w_bmask = 32'h0000_00FF << w_sh;

  always_comb begin
    o_rdata  = i_word;
    o_merged = i_wdata;
    case (i_size)
      SZ_HALF: begin
        if (i_off[1]) begin
          o_rdata  = {16'h0000, i_word[31:16]};
          o_merged = {i_wdata[15:0], i_word[15:0]};
        end else begin
          o_rdata  = {16'h0000, i_word[15:0]};
          o_merged = {i_word[31:16], i_wdata[15:0]};
        end
      end
      SZ_BYTE: begin
        o_rdata  = (i_word >> w_sh) & 32'h0000_00FF;
        o_merged = (i_word & ~w_bmask) | ({24'h000000, i_wdata[7:0]} << w_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory; runs
// one load/store at a time, doing read-modify-write for sub-word stores.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic        clk,
  input  logic        rst,
  dm_arbiter_if.slave bus
);

  logic [2:0]    r_state;
  logic          r_last;
  logic          r_port;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_wword;

  logic          w_sel;
  logic          w_grant;
  logic          w_fin;
  logic          w_in_we;
  logic [1:0]    w_in_size;
  logic [AW-1:0] w_in_addr;
  logic [31:0]   w_in_wdata;
  logic          w_in_bad;
  logic [31:0]   w_lane_rdata;
  logic [31:0]   w_lane_merged;

  // Contention goes to the port that did not win last; a lone requester always wins.
  assign w_sel      = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_grant    = (r_state == ST_IDLE) && (bus.req != 2'b00) && !rst;
  assign w_fin      = (r_state == ST_FIN);
  assign w_in_we    = w_sel ? bus.we[1] : bus.we[0];
  assign w_in_size  = w_sel ? bus.size1  : bus.size0;
  assign w_in_addr  = w_sel ? bus.addr1  : bus.addr0;
  assign w_in_wdata = w_sel ? bus.wdata1 : bus.wdata0;
  assign w_in_bad   = access_bad(w_in_size, w_in_addr[1:0]);

  assign bus.gnt       = {w_grant & w_sel, w_grant & ~w_sel};
  assign bus.done      = {w_fin & r_port, w_fin & ~r_port};
  assign bus.err       = w_fin & r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_we    = (r_state == ST_RMW_WR);
  assign bus.mem_addr  = r_addr[AW-1:2];
  assign bus.mem_wdata = r_wword;

  dm_lane u_lane (
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_word   (bus.mem_rdata),
    .i_wdata  (r_wdata),
    .o_rdata  (w_lane_rdata),
    .o_merged (w_lane_merged)
  );

  // Bad accesses spend one idle cycle in LOAD so every non-RMW access completes in two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_port <= w_sel;
            r_last <= w_sel;
            r_err  <= w_in_bad;
            if (w_in_bad || !w_in_we) r_state <= ST_LOAD;
            else if (w_in_size == SZ_WORD) r_state <= ST_RMW_WR;
            else r_state <= ST_RMW_RD;
          end
        end
        ST_LOAD: begin
          if (!r_err) r_rdata <= w_lane_rdata;
          r_state <= ST_FIN;
        end
        ST_RMW_RD: r_state <= ST_RMW_WR;
        ST_RMW_WR: r_state <= ST_FIN;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_size  <= w_in_size;
      r_addr  <= w_in_addr;
      r_wdata <= w_in_wdata;
      r_wword <= w_in_wdata;
    end else if (r_state == ST_RMW_RD) begin
      r_wword <= w_lane_merged;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed and random accesses checked against a
// byte-array memory model, plus arbitration and reset-abort scenarios.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int AW = 9;
  localparam int NW = 1 << (AW - 2);
  localparam int NB = 1 << AW;

  logic clk;
  logic rst;
  dm_arbiter_if #(.AW(AW)) bus ();

  dm_arbiter #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] bmem [0:NW-1];
  logic [7:0]  ref_mem [0:NB-1];
  logic [31:0] exp_rdata;
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = bmem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) bmem[bus.mem_addr] <= bus.mem_wdata;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int wi);
    return {ref_mem[4*wi+3], ref_mem[4*wi+2], ref_mem[4*wi+1], ref_mem[4*wi]};
  endfunction

  function automatic bit ref_bad(input logic [1:0] sz, input logic [AW-1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd0 && a[1:0] != 2'b00);
  endfunction

  task automatic set_port(input int p, input bit w, input logic [1:0] sz,
                          input logic [AW-1:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.we[0] = w; bus.size0 = sz; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.we[1] = w; bus.size1 = sz; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Called just after a rising edge with the arbiter idle.
  task automatic do_access(input string tag, input int p, input bit w, input logic [1:0] sz,
                           input logic [AW-1:0] a, input logic [31:0] d);
    bit bad, got, seen;
    int nb, lat, nwe, nwe_exp, idx;
    logic [31:0] exp_wd;
    bad = ref_bad(sz, a);
    nb = 4 >> sz;
    idx = int'(a) >> 2;
    lat = (!bad && w && sz != 2'd0) ? 3 : 2;
    nwe_exp = 0;
    exp_wd = 32'h0;
    if (!bad) begin
      if (w) begin
        for (int b = 0; b < nb; b++) ref_mem[int'(a) + b] = d[8*b +: 8];
        exp_wd = ref_word(idx);
        nwe_exp = 1;
      end else begin
        exp_rdata = 32'h0;
        for (int b = 0; b < nb; b++) exp_rdata[8*b +: 8] = ref_mem[int'(a) + b];
      end
    end
    set_port(p, w, sz, a, d);
    bus.req = (p == 0) ? 2'b01 : 2'b10;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        got = 1;
        chk({tag, "_gnt"}, {30'h0, bus.gnt}, (p == 0) ? 32'h1 : 32'h2);
      end
      @(posedge clk); #1;
    end
    bus.req = 2'b00;
    if (!got) begin
      chk({tag, "_gnt_timeout"}, 32'h0, 32'h1);
      return;
    end
    seen = 0;
    nwe = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        nwe++;
        chk({tag, "_midx"}, {{(34-AW){1'b0}}, bus.mem_addr}, idx);
        chk({tag, "_mwdata"}, bus.mem_wdata, exp_wd);
      end
      if (bus.done != 2'b00) begin
        seen = 1;
        chk({tag, "_done"}, {30'h0, bus.done}, (p == 0) ? 32'h1 : 32'h2);
        chk({tag, "_lat"}, i, lat);
        chk({tag, "_err"}, {31'h0, bus.err}, {31'h0, bad});
        chk({tag, "_rdata"}, bus.rdata, exp_rdata);
      end
      @(posedge clk); #1;
    end
    if (!seen) chk({tag, "_done_timeout"}, 32'h0, 32'h1);
    chk({tag, "_nwe"}, nwe, nwe_exp);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_rdata = 32'h0;
  endtask

  initial begin
    int ng, nd;
    logic [31:0] r;
    logic [1:0] sz;
    n_checks = 0;
    n_fail = 0;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.size0 = 2'b00; bus.size1 = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    for (int i = 0; i < NW; i++) begin
      r = $urandom;
      bmem[i] = r;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = r[8*b +: 8];
    end

    pulse_reset();
    @(negedge clk);
    chk("rst_gnt", {30'h0, bus.gnt}, 32'h0);
    chk("rst_done", {30'h0, bus.done}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;

    do_access("w034", 0, 1, SZ_WORD, 9'h010, 32'hDEADBEEF);
    do_access("l034", 0, 0, SZ_WORD, 9'h010, 32'h0);
    chk("l034_val", bus.rdata, 32'hDEADBEEF);

    do_access("w035", 1, 1, SZ_WORD, 9'h020, 32'h11223344);
    do_access("b035", 0, 1, SZ_BYTE, 9'h022, 32'h000000AA);
    chk("b035_mem", bmem[8], 32'h11AA3344);
    do_access("lb035", 1, 0, SZ_BYTE, 9'h022, 32'h0);
    chk("lb035_val", bus.rdata, 32'h000000AA);

    do_access("h037", 0, 1, SZ_HALF, 9'h021, 32'h5A5A5A5A);
    chk("h037_mem", bmem[8], 32'h11AA3344);
    do_access("r037", 1, 1, SZ_RSVD, 9'h024, 32'h12345678);
    do_access("lh", 0, 0, SZ_HALF, 9'h022, 32'h0);
    chk("lh_val", bus.rdata, 32'h000011AA);

    // Both ports requesting loads back-to-back from reset.
    pulse_reset();
    set_port(0, 0, SZ_WORD, 9'h040, 32'h0);
    set_port(1, 0, SZ_WORD, 9'h080, 32'h0);
    bus.req = 2'b11;
    ng = 0;
    nd = 0;
    for (int i = 0; i < 40 && nd < 4; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        chk("arb_done", {30'h0, bus.done}, (nd % 2 == 0) ? 32'h1 : 32'h2);
        chk("arb_rdata", bus.rdata, (nd % 2 == 0) ? ref_word(9'h040 >> 2) : ref_word(9'h080 >> 2));
        nd++;
      end
      if (bus.gnt != 2'b00) begin
        chk("arb_gnt", {30'h0, bus.gnt}, (ng % 2 == 0) ? 32'h1 : 32'h2);
        ng++;
      end
      @(posedge clk); #1;
      if (ng >= 4) bus.req = 2'b00;
    end
    chk("arb_ngnt", ng, 4);
    chk("arb_ndone", nd, 4);
    exp_rdata = ref_word(9'h080 >> 2);

    // Reset during the read half of a byte store.
    set_port(0, 1, SZ_BYTE, 9'h031, 32'h000000C3);
    bus.req = 2'b01;
    @(negedge clk);
    chk("abt_gnt", {30'h0, bus.gnt}, 32'h1);
    @(posedge clk); #1;
    bus.req = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abt_mem_we", {31'h0, bus.mem_we}, 32'h0);
      chk("abt_done", {30'h0, bus.done}, 32'h0);
      @(posedge clk); #1;
    end
    chk("abt_rdata", bus.rdata, 32'h0);
    chk("abt_mem", bmem[9'h030 >> 2], ref_word(9'h030 >> 2));
    set_port(0, 0, SZ_WORD, 9'h030, 32'h0);
    set_port(1, 0, SZ_WORD, 9'h034, 32'h0);
    bus.req = 2'b11;
    @(negedge clk);
    chk("abt_first_gnt", {30'h0, bus.gnt}, 32'h1);
    @(posedge clk); #1;
    bus.req = 2'b00;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        nd++;
        chk("abt_ld_done", {30'h0, bus.done}, 32'h1);
        chk("abt_ld_rdata", bus.rdata, ref_word(9'h030 >> 2));
      end
      @(posedge clk); #1;
    end
    chk("abt_ld_ndone", nd, 1);
    exp_rdata = ref_word(9'h030 >> 2);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 7);
      sz = (r < 7) ? 2'(r % 3) : 2'd3;
      do_access("rnd", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                AW'($urandom_range(0, NB - 1)), $urandom);
    end

    for (int i = 0; i < NW; i++) chk("final_mem", bmem[i], ref_word(i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 9, byte-address width (data memory of 2^(AW-2) words).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  2  per-port request; port 0 = CPU, port 1 = DMA/debug.
REQ-005 we  in  2  per-port write enable (1 = store, 0 = load).
REQ-006 size0, size1  in  2 each  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-007 addr0, addr1  in  AW each  byte address.
REQ-008 wdata0, wdata1  in  32 each  store data, right-aligned.
REQ-009 gnt  out  2  one-hot, one-cycle pulse: request accepted.
REQ-010 done  out  2  one-hot, one-cycle pulse: access complete; rdata/err valid with it.
REQ-011 rdata  out  32  load data, right-aligned, zero-extended.
REQ-012 err  out  1  misaligned or reserved-size access; qualifies done.
REQ-013 mem_we  out  1  data-memory write strobe.
REQ-014 mem_addr  out  AW-2  word index (byte address bits AW-1:2).
REQ-015 mem_wdata  out  32  full word to memory.
REQ-016 mem_rdata  in  32  memory read word, combinational from mem_addr.

Function
REQ-017 FSM states IDLE, LOAD, RMW_RD, RMW_WR, FIN; at most one access in flight.
REQ-018 IDLE, no req: stay IDLE, gnt=0, mem_we=0.
REQ-019 IDLE, req present: grant one port in the same cycle; latch port, we, size, addr, wdata.
REQ-020 Both req in same cycle: round-robin; grant port opposite to last granted; after reset last-granted = 1 (port 0 wins first).
REQ-021 Requester holds req/addr/wdata until gnt; req held after done counts as new request.
REQ-022 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; violation or size 11 -> FIN with err=1, no mem_we.
REQ-023 Word store: next cycle mem_we=1 with wdata -> FIN; total 2 cycles gnt-to-done.
REQ-024 Load: LOAD cycle samples mem_rdata, extracts lane by addr[1:0] (byte) / addr[1] (half), zero-extends, registers -> FIN.
REQ-025 Sub-word store: RMW_RD captures mem_rdata; RMW_WR drives mem_we=1 with merged word (only target lane replaced, lanes little-endian: byte 0 = bits 7:0) -> FIN.
REQ-026 FIN: pulse done for granted port, rdata/err valid; return IDLE; new grant possible next cycle.
REQ-027 Latency gnt->done: 2 cycles word store/load/error, 3 cycles sub-word store.
REQ-028 mem_addr driven from latched address in all non-IDLE states; mem_we=0 outside the single write cycle.
REQ-029 rdata holds last load value until next load completes; undefined content after store not permitted (holds).

Reset
REQ-030 rst forces IDLE, gnt=0, done=0, err=0, mem_we=0, rdata=0, last-granted=1 on the next edge.
REQ-031 rst mid-access (any state) aborts it: no mem_we on the following cycle, no done pulse.

Structure
REQ-032 Shared package holds size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and FSM state encoding, also used by sccpu and dm.
REQ-033 One sub-module, dm_lane: combinational lane extract (load) and lane merge (store) from addr[1:0], size.

Verification
REQ-034 Word store port 0 addr 0x10 data 0xDEADBEEF -> gnt0 cycle 0, mem_we cycle 1 idx 4, done0 cycle 2; load back rdata=0xDEADBEEF.
REQ-035 Mem word 0x11223344 at 0x20, byte store 0xAA addr 0x22 -> mem_wdata 0x11AA3344, done at 3 cycles; byte load 0x22 -> 0x000000AA.
REQ-036 Both ports req continuously after reset -> gnt sequence 0,1,0,1; no done overlap.
REQ-037 Half store addr 0x21 -> done with err=1, mem_we never asserted, memory unchanged.
REQ-038 rst asserted in RMW_RD -> next cycle IDLE, mem_we=0, no done; subsequent port-0 request granted first.
